// File: rtl/score_keeper.sv
// Score, lives, wave and high-score keeper for the invader game.
// Ports: clk, rst (async, active-high); start, frame_tick,
//   invader_collision[N_INV], player_collision[2] in;
//   score, high_score, lives, wave, state, done,
//   wave_clear, extra_life out (all registered).
module score_keeper #(
  parameter int N_INV             = 6,
  parameter int POINTS            = 10,
  parameter int SCORE_W           = 14,
  parameter int SCORE_MAX         = 9999,
  parameter int LIFE_W            = 2,
  parameter int START_LIVES       = 3,
  parameter int EXTRA_LIFE_AT     = 1000,
  parameter int INVADERS_PER_WAVE = 55,
  parameter int KILL_W            = 6,
  parameter int WAVE_W            = 4,
  parameter int RESPAWN_FRAMES    = 60
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               frame_tick,
  input  logic [N_INV-1:0]   invader_collision,
  input  logic [1:0]         player_collision,
  output logic [SCORE_W-1:0] score,
  output logic [SCORE_W-1:0] high_score,
  output logic [LIFE_W-1:0]  lives,
  output logic [WAVE_W-1:0]  wave,
  output logic [1:0]         state,
  output logic               done,
  output logic               wave_clear,
  output logic               extra_life
);

  localparam int HIT_W  = $clog2(N_INV + 1);
  localparam int SUM_W  = SCORE_W + $clog2(N_INV * POINTS + 1);
  localparam int KS_W   = KILL_W + 1;
  localparam int LN_W   = LIFE_W + 1;
  localparam int RESP_W = $clog2(RESPAWN_FRAMES + 1);
  localparam int LIFE_MAX = (2 ** LIFE_W) - 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PLAYING = 2'd1,
    RESPAWN = 2'd2,
    OVER    = 2'd3
  } state_t;

  state_t st, st_n;

  logic [KILL_W-1:0]  kills, kills_n;
  logic [RESP_W-1:0]  resp, resp_n;
  logic               granted, granted_n;
  logic [SCORE_W-1:0] score_n, hs_n;
  logic [LIFE_W-1:0]  lives_n;
  logic [WAVE_W-1:0]  wave_n;
  logic               wc_n, el_n, done_n;

  logic [HIT_W-1:0]   hits;
  logic [SUM_W-1:0]   score_sum;
  logic [SCORE_W-1:0] score_sat;
  logic [KS_W-1:0]    kill_sum;
  logic [LN_W-1:0]    life_net;
  logic [LIFE_W-1:0]  life_sat;
  logic               active, award, death;

  always_comb begin
    hits = '0;
    for (int i = 0; i < N_INV; i++) begin
      hits = hits + HIT_W'(invader_collision[i]);
    end
  end

  // Sum is wide enough for a full-row hit on top of any score,
  // so saturation never sees a wrapped value.
  always_comb begin
    score_sum = SUM_W'(score)
              + SUM_W'(hits) * SUM_W'(POINTS);
    if (score_sum > SUM_W'(SCORE_MAX)) begin
      score_sat = SCORE_W'(SCORE_MAX);
    end else begin
      score_sat = score_sum[SCORE_W-1:0];
    end
  end

  assign active = (st == PLAYING) || (st == RESPAWN);
  assign death  = (st == PLAYING) && (|player_collision);

  assign award = active && !granted
              && (score < SCORE_W'(EXTRA_LIFE_AT))
              && (score_sat >= SCORE_W'(EXTRA_LIFE_AT));

  assign kill_sum = KS_W'(kills) + KS_W'(hits);

  // Lives in PLAYING are always >= 1, so the net never underflows.
  always_comb begin
    life_net = LN_W'(lives) + LN_W'(award) - LN_W'(death);
    if (life_net > LN_W'(LIFE_MAX)) begin
      life_sat = LIFE_W'(LIFE_MAX);
    end else begin
      life_sat = life_net[LIFE_W-1:0];
    end
  end

  always_comb begin
    st_n      = st;
    score_n   = score;
    hs_n      = high_score;
    lives_n   = lives;
    wave_n    = wave;
    kills_n   = kills;
    resp_n    = resp;
    granted_n = granted;
    wc_n      = 1'b0;
    el_n      = 1'b0;
    unique case (st)
      IDLE, OVER: begin
        if (start) begin
          st_n      = PLAYING;
          score_n   = '0;
          lives_n   = LIFE_W'(START_LIVES);
          wave_n    = '0;
          kills_n   = '0;
          granted_n = 1'b0;
        end
      end
      PLAYING, RESPAWN: begin
        score_n = score_sat;
        lives_n = life_sat;
        if (award) begin
          granted_n = 1'b1;
          el_n      = 1'b1;
        end
        // Hits beyond the wave quota are dropped.
        if (kill_sum >= KS_W'(INVADERS_PER_WAVE)) begin
          kills_n = '0;
          wave_n  = wave + WAVE_W'(1);
          wc_n    = 1'b1;
        end else begin
          kills_n = kill_sum[KILL_W-1:0];
        end
        if (death) begin
          if (life_net == '0) begin
            st_n = OVER;
            hs_n = (score_sat > high_score) ? score_sat
                                            : high_score;
          end else begin
            st_n   = RESPAWN;
            resp_n = RESP_W'(RESPAWN_FRAMES);
          end
        end else if ((st == RESPAWN) && frame_tick) begin
          resp_n = resp - RESP_W'(1);
          if (resp == RESP_W'(1)) begin
            st_n = PLAYING;
          end
        end
      end
      default: ;
    endcase
    done_n = (st_n == OVER);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st         <= IDLE;
      score      <= '0;
      high_score <= '0;
      lives      <= '0;
      wave       <= '0;
      kills      <= '0;
      resp       <= '0;
      granted    <= 1'b0;
      done       <= 1'b0;
      wave_clear <= 1'b0;
      extra_life <= 1'b0;
    end else begin
      st         <= st_n;
      score      <= score_n;
      high_score <= hs_n;
      lives      <= lives_n;
      wave       <= wave_n;
      kills      <= kills_n;
      resp       <= resp_n;
      granted    <= granted_n;
      done       <= done_n;
      wave_clear <= wc_n;
      extra_life <= el_n;
    end
  end

  assign state = st;

endmodule

// File: tb/tb_score_keeper.sv
// Testbench for score_keeper: directed scenarios plus
// randomized play checked against a spec-level model.
module tb_score_keeper;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        frame_tick;
  logic [5:0]  invader_collision;
  logic [1:0]  player_collision;
  logic [13:0] score;
  logic [13:0] high_score;
  logic [1:0]  lives;
  logic [3:0]  wave;
  logic [1:0]  state;
  logic        done;
  logic        wave_clear;
  logic        extra_life;

  int total = 0;
  int bad   = 0;

  int m_state, m_score, m_hs, m_lives, m_wave;
  int m_kills, m_resp, m_granted, m_wc, m_el;

  score_keeper dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .frame_tick(frame_tick),
    .invader_collision(invader_collision),
    .player_collision(player_collision),
    .score(score),
    .high_score(high_score),
    .lives(lives),
    .wave(wave),
    .state(state),
    .done(done),
    .wave_clear(wave_clear),
    .extra_life(extra_life)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_state = 0; m_score = 0; m_hs = 0; m_lives = 0;
    m_wave = 0; m_kills = 0; m_resp = 0; m_granted = 0;
    m_wc = 0; m_el = 0;
  endtask

  function automatic logic [38:0] exp_vec();
    return {14'(m_score), 14'(m_hs), 2'(m_lives),
            4'(m_wave), 2'(m_state), (m_state == 3),
            1'(m_wc), 1'(m_el)};
  endfunction

  function automatic logic [38:0] act_vec();
    return {score, high_score, lives, wave, state,
            done, wave_clear, extra_life};
  endfunction

  // Drive one cycle of inputs, advance the model, sample after edge.
  task automatic step(input bit s, input bit ft,
                      input logic [5:0] ic,
                      input logic [1:0] pc);
    int h, ns, nl;
    bit aw, dth;
    start = s;
    frame_tick = ft;
    invader_collision = ic;
    player_collision = pc;
    m_wc = 0;
    m_el = 0;
    if (m_state == 0 || m_state == 3) begin
      if (s) begin
        m_state = 1; m_score = 0; m_lives = 3;
        m_wave = 0; m_kills = 0; m_granted = 0;
      end
    end else begin
      h = $countones(ic);
      ns = m_score + h * 10;
      if (ns > 9999) ns = 9999;
      aw = (m_granted == 0) && (m_score < 1000) && (ns >= 1000);
      if (m_kills + h >= 55) begin
        m_kills = 0;
        m_wave = (m_wave + 1) % 16;
        m_wc = 1;
      end else begin
        m_kills = m_kills + h;
      end
      dth = (m_state == 1) && (pc != 0);
      nl = m_lives - int'(dth) + int'(aw);
      if (nl > 3) nl = 3;
      if (aw) begin
        m_granted = 1;
        m_el = 1;
      end
      if (dth) begin
        if (nl == 0) begin
          m_state = 3;
          if (ns > m_hs) m_hs = ns;
        end else begin
          m_state = 2;
          m_resp = 60;
        end
      end else if (m_state == 2 && ft) begin
        m_resp = m_resp - 1;
        if (m_resp == 0) m_state = 1;
      end
      m_score = ns;
      m_lives = nl;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    frame_tick = 1'b0;
    invader_collision = '0;
    player_collision = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (act_vec() !== 39'd0) begin
      bad++;
      $display("FAIL reset: got %h want 0", act_vec());
    end
    #2 rst = 1'b0;
    step(0, 0, 6'b111111, 2'b11);
    total++;
    if (state !== 2'd0 || score !== 14'd0) begin
      bad++;
      $display("FAIL idle_hits: state=%0d score=%0d want 0/0",
               state, score);
    end
  endtask

  task automatic test_start();
    step(1, 0, 6'b111111, 2'b11);
    total++;
    if ({state, lives, score, wave, done} !==
        {2'd1, 2'd3, 14'd0, 4'd0, 1'b0}) begin
      bad++;
      $display("FAIL start: st=%0d lv=%0d sc=%0d wv=%0d dn=%0d want 1/3/0/0/0",
               state, lives, score, wave, done);
    end
  endtask

  task automatic test_score();
    step(0, 0, 6'b101101, 2'b00);
    total++;
    if ({score, wave_clear, extra_life} !== {14'd40, 2'b00}) begin
      bad++;
      $display("FAIL score40: sc=%0d wc=%0d el=%0d want 40/0/0",
               score, wave_clear, extra_life);
    end
  endtask

  task automatic test_respawn();
    step(0, 0, 6'b000000, 2'b01);
    total++;
    if (lives !== 2'd2 || state !== 2'd2) begin
      bad++;
      $display("FAIL death: lv=%0d st=%0d want 2/2", lives, state);
    end
    step(0, 0, 6'b000000, 2'b11);
    step(0, 0, 6'b000000, 2'b10);
    total++;
    if (lives !== 2'd2 || state !== 2'd2) begin
      bad++;
      $display("FAIL invuln: lv=%0d st=%0d want 2/2", lives, state);
    end
    for (int i = 0; i < 59; i++) begin
      step(0, 1, 6'b000000, (i % 7 == 0) ? 2'b01 : 2'b00);
      if (i == 30) step(0, 0, 6'b000000, 2'b00);
    end
    total++;
    if (state !== 2'd2) begin
      bad++;
      $display("FAIL tick59: st=%0d want 2", state);
    end
    step(0, 1, 6'b000000, 2'b00);
    total++;
    if (state !== 2'd1 || lives !== 2'd2) begin
      bad++;
      $display("FAIL tick60: st=%0d lv=%0d want 1/2", state, lives);
    end
  endtask

  task automatic test_extra_life();
    int rem;
    for (int g = 0; g < 200 && m_score + 60 <= 990; g++)
      step(0, 0, 6'b111111, 2'b00);
    rem = (990 - m_score) / 10;
    step(0, 0, 6'((1 << rem) - 1), 2'b00);
    total++;
    if (score !== 14'd990 || extra_life !== 1'b0) begin
      bad++;
      $display("FAIL to990: sc=%0d el=%0d want 990/0", score, extra_life);
    end
    step(0, 0, 6'b000011, 2'b00);
    total++;
    if ({score, extra_life, lives} !== {14'd1010, 1'b1, 2'd3}) begin
      bad++;
      $display("FAIL award: sc=%0d el=%0d lv=%0d want 1010/1/3",
               score, extra_life, lives);
    end
    step(0, 0, 6'b000001, 2'b00);
    total++;
    if ({score, extra_life, lives} !== {14'd1020, 1'b0, 2'd3}) begin
      bad++;
      $display("FAIL no_second: sc=%0d el=%0d lv=%0d want 1020/0/3",
               score, extra_life, lives);
    end
    total++;
    if (act_vec() !== exp_vec()) begin
      bad++;
      $display("FAIL el_sync: got %h want %h", act_vec(), exp_vec());
    end
  endtask

  task automatic test_game_over();
    int sc;
    for (int g = 0; g < 5 && m_lives > 1; g++) begin
      step(0, 0, 6'b000000, 2'b01);
      for (int k = 0; k < 60; k++) step(0, 1, 6'b000000, 2'b00);
    end
    total++;
    if (lives !== 2'd1 || state !== 2'd1) begin
      bad++;
      $display("FAIL last_life: lv=%0d st=%0d want 1/1", lives, state);
    end
    sc = m_score + 10;
    step(0, 0, 6'b000001, 2'b10);
    total++;
    if ({state, done, lives, score, high_score} !==
        {2'd3, 1'b1, 2'd0, 14'(sc), 14'(sc)}) begin
      bad++;
      $display("FAIL over: st=%0d dn=%0d lv=%0d sc=%0d hs=%0d want 3/1/0/%0d/%0d",
               state, done, lives, score, high_score, sc, sc);
    end
    step(0, 1, 6'b111111, 2'b11);
    step(0, 0, 6'b111111, 2'b01);
    total++;
    if ({state, done, score} !== {2'd3, 1'b1, 14'(sc)}) begin
      bad++;
      $display("FAIL over_hold: st=%0d dn=%0d sc=%0d want 3/1/%0d",
               state, done, score, sc);
    end
    step(1, 0, 6'b111111, 2'b00);
    total++;
    if ({state, done, score, high_score} !==
        {2'd1, 1'b0, 14'd0, 14'(sc)}) begin
      bad++;
      $display("FAIL restart: st=%0d dn=%0d sc=%0d hs=%0d want 1/0/0/%0d",
               state, done, score, high_score, sc);
    end
  endtask

  task automatic test_wave_clear();
    bit seen;
    for (int i = 0; i < 9; i++) step(0, 0, 6'b111111, 2'b00);
    total++;
    if (wave !== 4'd0 || wave_clear !== 1'b0) begin
      bad++;
      $display("FAIL k54: wv=%0d wc=%0d want 0/0", wave, wave_clear);
    end
    step(0, 0, 6'b100001, 2'b00);
    total++;
    if (wave !== 4'd1 || wave_clear !== 1'b1) begin
      bad++;
      $display("FAIL clear1: wv=%0d wc=%0d want 1/1", wave, wave_clear);
    end
    seen = 0;
    for (int i = 0; i < 9; i++) begin
      step(0, 0, 6'b111111, 2'b00);
      if (wave_clear) seen = 1;
    end
    total++;
    if (seen !== 1'b0 || wave !== 4'd1) begin
      bad++;
      $display("FAIL restart_kills: wc_seen=%0d wv=%0d want 0/1", seen, wave);
    end
    step(0, 0, 6'b000100, 2'b00);
    total++;
    if (wave !== 4'd2 || wave_clear !== 1'b1) begin
      bad++;
      $display("FAIL clear2: wv=%0d wc=%0d want 2/1", wave, wave_clear);
    end
  endtask

  task automatic test_saturation();
    int rem;
    for (int g = 0; g < 400 && m_score <= 9930; g++)
      step(0, 0, 6'b111111, 2'b00);
    rem = (9990 - m_score) / 10;
    step(0, 0, 6'((1 << rem) - 1), 2'b00);
    total++;
    if (score !== 14'd9990) begin
      bad++;
      $display("FAIL to9990: sc=%0d want 9990", score);
    end
    step(0, 0, 6'b111111, 2'b00);
    total++;
    if (score !== 14'd9999) begin
      bad++;
      $display("FAIL sat: sc=%0d want 9999", score);
    end
    step(0, 0, 6'b111111, 2'b00);
    total++;
    if (act_vec() !== exp_vec()) begin
      bad++;
      $display("FAIL sat_hold: got %h want %h", act_vec(), exp_vec());
    end
  endtask

  task automatic test_reset_mid();
    step(0, 0, 6'b000000, 2'b01);
    for (int i = 0; i < 5; i++) step(0, 1, 6'b000000, 2'b00);
    total++;
    if (state !== 2'd2) begin
      bad++;
      $display("FAIL pre_rst: st=%0d want 2", state);
    end
    #3 rst = 1'b1;
    #1;
    model_reset();
    total++;
    if (act_vec() !== 39'd0) begin
      bad++;
      $display("FAIL async_rst: got %h want 0", act_vec());
    end
    #2 rst = 1'b0;
    step(0, 0, 6'b000000, 2'b00);
  endtask

  task automatic test_random();
    bit s, ft;
    logic [5:0] ic;
    logic [1:0] pc;
    for (int i = 0; i < 3000; i++) begin
      s = ($urandom_range(0, 99) < 3);
      ft = $urandom_range(0, 1) != 0;
      ic = 6'($urandom);
      pc = ($urandom_range(0, 39) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      step(s, ft, ic, pc);
      total++;
      if (act_vec() !== exp_vec()) begin
        bad++;
        $display("FAIL random[%0d]: got %h want %h", i, act_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_start();
    test_score();
    test_respawn();
    test_extra_life();
    test_game_over();
    test_wave_clear();
    test_saturation();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
